packet_arbiter_ic: RTL and testbench

- N-to-1 packet interconnect. Merges CONNECT_NUM valid/ready input streams into one output stream.
- Sits between a set of producer stages and a single downstream consumer stage.
- Arbitrates among the inputs that have a packet pending.
- Forwards the winning packet through a one-entry registered output stage.

---
 rtl/packet_arbiter_ic_pkg.sv | 12 +
 rtl/packet_arbiter_ic_if.sv | 26 ++
 rtl/packet_arbiter_ic_grant_arbiter.sv | 65 ++++++
 rtl/packet_arbiter_ic.sv | 57 +++++
 tb/tb_packet_arbiter_ic.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/packet_arbiter_ic_pkg.sv
// Shared constants and handshake helper for the packet_arbiter_ic interconnect.
// Optional round-robin arbitration is selected with IC_ROUND_ROBIN_EN.
package packet_arbiter_ic_pkg;

  localparam int unsigned PACKET_WIDTH        = 192;
  localparam int unsigned DEFAULT_CONNECT_NUM = 3;

  function automatic logic handshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/packet_arbiter_ic_if.sv
// Bundles the N input streams and the single output stream of packet_arbiter_ic.
interface packet_arbiter_ic_if
  import packet_arbiter_ic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PACKET_WIDTH,
  parameter int unsigned CONNECT_NUM = DEFAULT_CONNECT_NUM
);

  logic [CONNECT_NUM-1:0]            RECEIVE_VALID;
  logic [CONNECT_NUM-1:0]            RECEIVE_READY;
  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA;
  logic                              SEND_VALID;
  logic                              SEND_READY;
  logic [DATA_WIDTH-1:0]             SEND_DATA;

  modport master (
    output RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    input  RECEIVE_READY, SEND_VALID, SEND_DATA
  );

  modport slave (
    input  RECEIVE_VALID, RECEIVE_DATA, SEND_READY,
    output RECEIVE_READY, SEND_VALID, SEND_DATA
  );

endinterface

// File: rtl/packet_arbiter_ic_grant_arbiter.sv
// Request-to-one-hot grant: highest index wins, or a descending round-robin search
// from a pointer when IC_ROUND_ROBIN_EN is defined.
module ic_grant_arbiter
  import packet_arbiter_ic_pkg::*;
#(
  parameter int unsigned CONNECT_NUM = DEFAULT_CONNECT_NUM
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CONNECT_NUM-1:0] req,
  input  logic                   advance,
  output logic [CONNECT_NUM-1:0] grant
);

`ifdef IC_ROUND_ROBIN_EN
  localparam int unsigned PtrW = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;
  localparam logic [PtrW-1:0] PtrMax = PtrW'(CONNECT_NUM - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int              idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(CONNECT_NUM); k++) begin
      idx = (int'(ptr_q) - k + int'(CONNECT_NUM)) % int'(CONNECT_NUM);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // After serving input g the search restarts just below g, wrapping to the top.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int unsigned g = 0; g < CONNECT_NUM; g++) begin
        if (grant[g]) ptr_d = (g == 0) ? PtrMax : PtrW'(g - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PtrMax;
    else        ptr_q <= ptr_d;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, advance};

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < CONNECT_NUM; i++) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/packet_arbiter_ic.sv
// N-to-1 packet interconnect: arbitrates pending inputs into a one-entry output register.
// Define IC_ROUND_ROBIN_EN for round-robin instead of fixed highest-index priority.
module packet_arbiter_ic
  import packet_arbiter_ic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = PACKET_WIDTH,
  parameter int unsigned CONNECT_NUM = DEFAULT_CONNECT_NUM
) (
  input logic                CLK,
  input logic                RST,
  packet_arbiter_ic_if.slave bus
);

  logic                   out_valid;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic [CONNECT_NUM-1:0] grant;
  logic                   load_en;
  logic                   any_valid;

  assign any_valid = |bus.RECEIVE_VALID;
  // The entry refills in the same cycle it drains.
  assign load_en   = !out_valid || handshake(out_valid, bus.SEND_READY);

  ic_grant_arbiter #(
    .CONNECT_NUM (CONNECT_NUM)
  ) u_grant_arbiter (
    .clk     (CLK),
    .rst_n   (RST),
    .req     (bus.RECEIVE_VALID),
    .advance (load_en && any_valid && RST),
    .grant   (grant)
  );

  always_comb begin
    mux_data = '0;
    for (int unsigned i = 0; i < CONNECT_NUM; i++) begin
      mux_data = mux_data | (bus.RECEIVE_DATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
    end
  end

  // Nothing is accepted while reset is held, even though the empty entry could load.
  assign bus.RECEIVE_READY = grant & {CONNECT_NUM{load_en & RST}};
  assign bus.SEND_VALID    = out_valid;
  assign bus.SEND_DATA     = out_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_en) begin
      out_valid <= any_valid;
      if (any_valid) out_data <= mux_data;
    end
  end

endmodule

// File: tb/tb_packet_arbiter_ic.sv
// Randomized directed bench for packet_arbiter_ic against a pending-set reference model.
module tb_packet_arbiter_ic;
  localparam int unsigned W = packet_arbiter_ic_pkg::PACKET_WIDTH;
  localparam int N = 3;

  logic CLK;
  logic RST;

  packet_arbiter_ic_if #(.DATA_WIDTH(W), .CONNECT_NUM(N)) bus ();

  packet_arbiter_ic #(
    .DATA_WIDTH  (W),
    .CONNECT_NUM (N)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: per-input pending packet plus the expected output entry.
  bit           src_pend [N];
  logic [W-1:0] src_pkt  [N];
  bit           refill   [N];
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_ptr;
  int           obs_w;
  int           n_issued, n_seen;
  int           n_checks, n_pass, n_fail;
  logic [W-1:0] p [N];
  int           exp_seq [6];
  int           perm [N];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 32); i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic raise(input int i);
    src_pend[i] = 1'b1;
    src_pkt[i]  = rnd();
    n_issued++;
  endtask

  function automatic int pick();
    int w;
    w = -1;
`ifdef IC_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr - k + N) % N;
      if (w < 0 && src_pend[idx]) w = idx;
    end
`else
    for (int i = 0; i < N; i++) if (src_pend[i]) w = i;
`endif
    return w;
  endfunction

  // One clock: drive, check ready, advance model at the edge, check outputs at negedge.
  task automatic cycle(input bit rdy);
    int w;
    bit load;
    logic [N-1:0] exp_rdy;
    bus.SEND_READY = rdy;
    for (int i = 0; i < N; i++) begin
      bus.RECEIVE_VALID[i]       = src_pend[i];
      bus.RECEIVE_DATA[i*W +: W] = src_pkt[i];
    end
    #1;
    w       = pick();
    load    = !m_valid || rdy;
    exp_rdy = '0;
    if (load && w >= 0) exp_rdy[w] = 1'b1;
    chk("recv_ready", bus.RECEIVE_READY, exp_rdy);
    obs_w = -1;
    for (int i = 0; i < N; i++) if (bus.RECEIVE_READY[i]) obs_w = i;
    if (bus.SEND_VALID && rdy) n_seen++;
    @(posedge CLK);
    if (load) begin
      if (w >= 0) begin
        m_valid     = 1'b1;
        m_data      = src_pkt[w];
        src_pend[w] = 1'b0;
        m_ptr       = (w + N - 1) % N;
        if (refill[w]) raise(w);
      end else begin
        m_valid = 1'b0;
      end
    end
    @(negedge CLK);
    chk("send_valid", bus.SEND_VALID, m_valid);
    chk("send_data", bus.SEND_DATA, m_data);
  endtask

  task automatic drain();
    for (int k = 0; k < 8; k++) cycle(1'b1);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; n_issued = 0; n_seen = 0;
    for (int i = 0; i < N; i++) begin
      src_pend[i] = 1'b0; src_pkt[i] = '0; refill[i] = 1'b0;
    end
    m_valid = 1'b0; m_data = '0; m_ptr = N - 1;
    RST = 1'b0;
    bus.SEND_READY = 1'b0; bus.RECEIVE_VALID = '0; bus.RECEIVE_DATA = '0;

    // Reset held with random inputs: nothing accepted, output empty.
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      bus.RECEIVE_VALID = N'($urandom());
      for (int i = 0; i < N; i++) bus.RECEIVE_DATA[i*W +: W] = rnd();
      bus.SEND_READY = 1'($urandom());
      #1;
      chk("rst_send_valid", bus.SEND_VALID, 1'b0);
      chk("rst_recv_ready", bus.RECEIVE_READY, '0);
      chk("rst_send_data", bus.SEND_DATA, '0);
    end
    @(negedge CLK);
    bus.RECEIVE_VALID = '0;
    RST = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b1);

    // Concurrent arrival: expect DATA[2], DATA[1], DATA[0] back to back.
    for (int i = 0; i < N; i++) begin
      raise(i);
      p[i] = src_pkt[i];
    end
    for (int k = 0; k < N; k++) begin
      cycle(1'b1);
      chk("concurrent_order", bus.SEND_DATA, p[N-1-k]);
    end
    drain();

    // Inputs 1 and 2 continuously valid for six transfers.
`ifdef IC_ROUND_ROBIN_EN
    exp_seq[0] = 2; exp_seq[1] = 1; exp_seq[2] = 2;
    exp_seq[3] = 1; exp_seq[4] = 2; exp_seq[5] = 1;
`else
    for (int t = 0; t < 6; t++) exp_seq[t] = 2;
`endif
    refill[1] = 1'b1; refill[2] = 1'b1;
    raise(1); raise(2);
    for (int t = 0; t < 6; t++) begin
      cycle(1'b1);
      chk("grant_seq", obs_w, exp_seq[t]);
    end
    refill[1] = 1'b0; refill[2] = 1'b0;
    drain();

    // Staggered arrival 2,1,0 and 0,1,2, then 0,1,2 overlapping behind a stalled output.
    raise(2); cycle(1'b1); raise(1); cycle(1'b1); raise(0); cycle(1'b1); drain();
    raise(0); cycle(1'b1); raise(1); cycle(1'b1); raise(2); cycle(1'b1); drain();
    raise(0); cycle(1'b0); raise(1); cycle(1'b0); raise(2); cycle(1'b0); drain();

    // Backpressure: full output, inputs 0 and 2 pending, SEND_READY low for 5 cycles.
    raise(1); cycle(1'b0);
    raise(0); raise(2);
    for (int k = 0; k < 5; k++) cycle(1'b0);
    drain();

    // Soak: concurrent or shuffled staggered arrivals with random output stalls.
    for (int it = 0; it < 100; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < N; i++) raise(i);
        for (int k = 0; k < 3; k++) cycle(1'($urandom_range(0, 3) != 0));
      end else begin
        for (int i = 0; i < N; i++) perm[i] = i;
        for (int i = N - 1; i > 0; i--) begin
          int j, t;
          j = int'($urandom_range(0, i));
          t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < N; i++) begin
          raise(perm[i]);
          cycle(1'($urandom_range(0, 3) != 0));
        end
      end
      drain();
    end

    chk("delivered_count", n_seen, n_issued);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
